// File: rtl/memref_drain_pkg.sv
// Shared types and constants for the memref drain stream.
package memref_drain_pkg;

  // Drain controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Output buffer geometry: two entries, occupancy 0..2.
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  // Address width for a memref of `depth` elements; never narrower than 1 bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry register FIFO. The head is always slot0. Empty slots read back as zero,
// so dout is 0 whenever the FIFO is empty.
module sync_fifo2
  import memref_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_ok;

  // A pop on an empty FIFO is ignored.
  assign pop_ok = pop && (cnt_q != '0);

  // Slot/occupancy update. slot1 is kept at zero whenever it does not hold live data.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    unique case ({push, pop_ok})
      2'b10: begin
        if (cnt_q == '0) slot0_d = din;
        else             slot1_d = din;
        cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        slot1_d = '0;
        cnt_d   = cnt_q - CNT_W'(1);
      end
      2'b11: begin
        if (cnt_q == CNT_W'(1)) begin
          slot0_d = din;
        end else begin
          slot0_d = slot1_q;
          slot1_d = din;
        end
      end
      default: ;
    endcase
  end

  // Storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = slot0_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/memref_drain_stream.sv
// Reads a result memref back through a 1-cycle-latency read port and presents it,
// in address order, as a valid/ready stream with a last flag. Reads are credit-limited
// so that buffered plus in-flight elements never exceed the 2-entry output FIFO.
module memref_drain_stream
  import memref_drain_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  output logic              Ci_p0_addr_en,
  output logic [ADDR_W-1:0] Ci_p0_addr_data,
  output logic              Ci_p0_rd_en,
  input  logic [WIDTH-1:0]  Ci_p0_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  drain_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q;
  logic              inflight_last_q;

  logic [CNT_W-1:0]  fifo_cnt;
  logic [WIDTH:0]    fifo_dout;
  logic              pop;
  logic              issue;
  logic [2:0]        credit;

  // Beat handshake; the FIFO head drives the stream directly.
  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = fifo_dout[WIDTH-1:0];
  assign out_last  = fifo_dout[WIDTH];

  // Credit check: occupancy after this cycle's pop, counting the outstanding read.
  always_comb begin
    credit = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);
    issue  = (state_q == READ) && (credit < 3'(FIFO_DEPTH));
  end

  assign Ci_p0_rd_en     = issue;
  assign Ci_p0_addr_en   = issue;
  assign Ci_p0_addr_data = addr_q;
  assign busy            = (state_q == READ) || (state_q == FLUSH);
  assign done            = (state_q == DONE);

  // Next-state and address counter; t only matters in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (t) begin
          state_d = READ;
          addr_d  = '0;
        end
      end
      READ: begin
        if (issue) begin
          if (addr_q == LAST_ADDR) begin
            state_d = FLUSH;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      FLUSH: begin
        if (pop && out_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller registers; the in-flight flag marks read data arriving next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (addr_q == LAST_ADDR);
    end
  end

  // Returned read data is buffered together with its last flag.
  sync_fifo2 #(
    .WIDTH (WIDTH + 1)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (inflight_q),
    .din  ({inflight_last_q, Ci_p0_rd_data}),
    .pop  (pop),
    .dout (fifo_dout),
    .cnt  (fifo_cnt)
  );

endmodule

// File: tb/tb_memref_drain_stream.sv
// Bench for memref_drain_stream: a DEPTH=64 instance driven through several runs and
// a DEPTH=1 instance. Expected beats are queued when a run starts; monitors compare.
module tb_memref_drain_stream;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 64;
  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst;
  logic          t;
  logic          addr_en;
  logic [AW-1:0] addr_data;
  logic          rd_en;
  logic [W-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic          t1;
  logic          addr_en1;
  logic [0:0]    addr_data1;
  logic          rd_en1;
  logic [W-1:0]  rd_data1;
  logic          out_valid1;
  logic          out_ready1;
  logic [W-1:0]  out_data1;
  logic          out_last1;
  logic          busy1;
  logic          done1;

  int            n_vec = 0;
  int            n_fail = 0;
  logic [W:0]    exp_q[$];
  logic [W:0]    exp1_q[$];
  int            done_cnt = 0;
  int            done1_cnt = 0;
  int            beats1 = 0;
  int            issued = 0;
  int            accepted = 0;
  int            exp_addr = 0;
  int            cyc = 0;
  int            first_cyc = 0;
  int            last_cyc = 0;
  int            rd_after_drop = 0;
  logic          ready_low = 1'b0;
  logic          prev_v = 1'b0;
  logic          prev_r = 1'b0;
  logic [W:0]    prev_beat = '0;
  logic          last_acc_prev = 1'b0;
  logic          last_acc1_prev = 1'b0;

  memref_drain_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk), .rst (rst), .t (t),
    .Ci_p0_addr_en (addr_en), .Ci_p0_addr_data (addr_data),
    .Ci_p0_rd_en (rd_en), .Ci_p0_rd_data (rd_data),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
    .out_last (out_last), .busy (busy), .done (done)
  );

  memref_drain_stream #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk (clk), .rst (rst), .t (t1),
    .Ci_p0_addr_en (addr_en1), .Ci_p0_addr_data (addr_data1),
    .Ci_p0_rd_en (rd_en1), .Ci_p0_rd_data (rd_data1),
    .out_valid (out_valid1), .out_ready (out_ready1), .out_data (out_data1),
    .out_last (out_last1), .busy (busy1), .done (done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memref read port models, 1-cycle latency: mem[i] = A000_0000 + i, small mem[0] = 1234.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= 32'hA000_0000 + 32'(addr_data);
    if (rd_en1) rd_data1 <= (addr_data1 == 1'b0) ? 32'h0000_1234 : 32'hDEAD_BEEF;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Main monitor: scoreboard pops, read-address order, credit bound, hold and done timing.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      issued = 0; accepted = 0; exp_addr = 0;
      prev_v = 1'b0; last_acc_prev = 1'b0;
    end else begin
      if (busy || rd_en) begin
        check("outstanding<=2", 64'((issued - accepted) <= 2), 64'd1);
        check("addr_en==rd_en", 64'(addr_en), 64'(rd_en));
      end
      if (rd_en) begin
        check("rd_en while busy", 64'(busy), 64'd1);
        check("rd addr", 64'(addr_data), 64'(exp_addr));
        exp_addr++;
        issued++;
        if (ready_low) rd_after_drop++;
      end
      if (prev_v && !prev_r) begin
        check("hold valid", 64'(out_valid), 64'd1);
        check("hold beat", 64'({out_last, out_data}), 64'(prev_beat));
      end
      if (done || last_acc_prev) check("done timing", 64'(done), 64'(last_acc_prev));
      if (done) begin
        done_cnt++;
        exp_addr = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL extra beat: got %0h expected none", {out_last, out_data});
        end else begin
          if (exp_q.size() == D) first_cyc = cyc;
          if (exp_q[0][W]) last_cyc = cyc;
          check("beat", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
        accepted++;
      end
      last_acc_prev = out_valid && out_ready && out_last;
      prev_v    = out_valid;
      prev_r    = out_ready;
      prev_beat = {out_last, out_data};
    end
  end

  // DEPTH=1 monitor.
  always @(negedge clk) begin
    if (!rst) begin
      last_acc1_prev = 1'b0;
    end else begin
      if (rd_en1) begin
        check("d1 addr", 64'(addr_data1), 64'd0);
        check("d1 addr_en", 64'(addr_en1), 64'd1);
      end
      if (done1 || last_acc1_prev) check("d1 done timing", 64'(done1), 64'(last_acc1_prev));
      if (done1) done1_cnt++;
      if (out_valid1 && out_ready1) begin
        beats1++;
        if (exp1_q.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL d1 extra beat: got %0h expected none", {out_last1, out_data1});
        end else begin
          check("d1 beat", 64'({out_last1, out_data1}), 64'(exp1_q.pop_front()));
        end
      end
      last_acc1_prev = out_valid1 && out_ready1 && out_last1;
    end
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, " ctl outputs"}, 64'({rd_en, addr_en, addr_data, out_valid, out_last, busy, done}), 64'd0);
    check({nm, " out_data"}, 64'(out_data), 64'd0);
  endtask

  // mode 0: ready=1, 1: ready low for run cycles 5..14, 2: random ready.
  task automatic run(input int mode, input int retrig, input int rst_at);
    int  done0;
    bit  fin;
    done0 = done_cnt;
    for (int i = 0; i < int'(D); i++)
      exp_q.push_back({(i == int'(D) - 1), 32'hA000_0000 + 32'(i)});
    rd_after_drop = 0;
    t = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 1000 && !fin; c++) begin
      @(posedge clk); #1;
      t = (c == retrig);
      if (done) fin = 1'b1;
      case (mode)
        1:       out_ready = !(c >= 5 && c <= 14);
        2:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
      ready_low = !out_ready && (mode == 1);
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1 check_reset_outputs("async reset");
        exp_q.delete();
        @(posedge clk); @(posedge clk);
        #3 rst = 1'b1;
        fin = 1'b1;
      end
    end
    t = 1'b0;
    out_ready = 1'b1;
    ready_low = 1'b0;
    if (!fin) begin
      n_vec++; n_fail++;
      $display("FAIL run timeout: got no done expected done within 1000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    check("busy after run", 64'(busy), 64'd0);
    check("pending beats", 64'(exp_q.size()), 64'd0);
    if (rst_at >= 0) check("no done on reset", 64'(done_cnt), 64'(done0));
    else             check("done count", 64'(done_cnt), 64'(done0 + 1));
    if (mode == 0 && rst_at < 0)
      check("64 consecutive beats", 64'(last_cyc - first_cyc), 64'(D - 1));
    if (mode == 1)
      check("reads after ready drop <=2", 64'(rd_after_drop <= 2), 64'd1);
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b0;
    t = 1'b0;
    out_ready = 1'b1;
    t1 = 1'b0;
    out_ready1 = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset state");
    check("d1 reset outputs", 64'({rd_en1, out_valid1, out_last1, busy1, done1, out_data1}), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    run(0, -1, -1);   // full-rate drain
    run(1, -1, -1);   // backpressure window
    run(2, -1, -1);   // random ready
    run(0, 10, -1);   // t re-pulsed mid-run is ignored
    run(0, -1, -1);   // second identical run
    run(0, -1, 20);   // reset mid-run
    run(0, -1, -1);   // clean run after reset

    // DEPTH=1 build.
    exp1_q.push_back({1'b1, 32'h0000_1234});
    t1 = 1'b1;
    @(posedge clk); #1 t1 = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("d1 beats", 64'(beats1), 64'd1);
    check("d1 done count", 64'(done1_cnt), 64'd1);
    check("d1 busy after", 64'(busy1), 64'd0);
    check("d1 pending", 64'(exp1_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
